// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port synchronous data RAM between the load/store unit (port 0)
// and the loader (port 1), one access at a time, round-robin, with programmable wait cycles.
module dmem_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [31:0]           p0_addr,
    input  logic [31:0]           p0_wdata,
    output logic [31:0]           p0_rdata,
    output logic                  p0_stall,
    output logic                  p0_done,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [31:0]           p1_addr,
    input  logic [31:0]           p1_wdata,
    output logic [31:0]           p1_rdata,
    output logic                  p1_stall,
    output logic                  p1_done,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_di,
    input  logic [31:0]           mem_dout,
    output logic                  busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grant_q, grant_d;
    logic                  lat_we_q, lat_we_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_di_q, mem_di_d;
    logic [31:0]           p0_rdata_q, p0_rdata_d;
    logic [31:0]           p1_rdata_q, p1_rdata_d;
    logic                  winner_s;
    logic                  unused_addr_s;

    assign unused_addr_s = ^{p0_addr[31:ADDR_WIDTH+2], p0_addr[1:0],
                             p1_addr[31:ADDR_WIDTH+2], p1_addr[1:0]};

    // Arbitration: a lone requester wins; on a tie the port not granted last time wins.
    always_comb begin
        winner_s = 1'b0;
        if (p0_req && p1_req) begin
            winner_s = ~last_grant_q;
        end else if (p1_req) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Access sequencer: next state, latched request fields and read-data capture.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        lat_we_d     = lat_we_q;
        wait_cnt_d   = wait_cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_di_d     = mem_di_q;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (p0_req || p1_req) begin
                    state_d      = ST_ISSUE;
                    grant_d      = winner_s;
                    last_grant_d = winner_s;
                    lat_we_d     = winner_s ? p1_we : p0_we;
                    mem_addr_d   = winner_s ? p1_addr[ADDR_WIDTH+1:2] : p0_addr[ADDR_WIDTH+1:2];
                    mem_di_d     = winner_s ? p1_wdata : p0_wdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (lat_we_q) begin
                    p0_rdata_d = p0_rdata_q;
                end else if (grant_q) begin
                    p1_rdata_d = mem_dout;
                end else begin
                    p0_rdata_d = mem_dout;
                end
                state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'(WAIT_CYCLES - 1)) begin
                    wait_cnt_d = 4'd0;
                    state_d    = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register and latched fields; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            lat_we_q     <= 1'b0;
            wait_cnt_q   <= 4'd0;
            mem_addr_q   <= '0;
            mem_di_q     <= 32'd0;
            p0_rdata_q   <= 32'd0;
            p1_rdata_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            lat_we_q     <= lat_we_d;
            wait_cnt_q   <= wait_cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_di_q     <= mem_di_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

    // Strobes decoded from the state register so reset removes them at once.
    assign mem_we   = (state_q == ST_ISSUE) && lat_we_q;
    assign busy     = (state_q != ST_IDLE);
    assign p0_done  = (state_q == ST_RESP) && !grant_q;
    assign p1_done  = (state_q == ST_RESP) && grant_q;
    assign p0_stall = p0_req && !p0_done;
    assign p1_stall = p1_req && !p1_done;
    assign mem_addr = mem_addr_q;
    assign mem_di   = mem_di_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a WAIT_CYCLES=4 instance with a RAM model and a
// WAIT_CYCLES=0 instance for the address-wrap / minimum-latency case.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;

    logic        a_p0_req, a_p0_we, a_p1_req, a_p1_we;
    logic [31:0] a_p0_addr, a_p0_wdata, a_p1_addr, a_p1_wdata;
    logic [31:0] a_p0_rdata, a_p1_rdata;
    logic        a_p0_stall, a_p0_done, a_p1_stall, a_p1_done;
    logic        a_mem_we, a_busy;
    logic [15:0] a_mem_addr;
    logic [31:0] a_mem_di, a_mem_dout;

    logic        b_p0_req, b_p0_we, b_p1_req, b_p1_we;
    logic [31:0] b_p0_addr, b_p0_wdata, b_p1_addr, b_p1_wdata;
    logic [31:0] b_p0_rdata, b_p1_rdata;
    logic        b_p0_stall, b_p0_done, b_p1_stall, b_p1_done;
    logic        b_mem_we, b_busy;
    logic [15:0] b_mem_addr;
    logic [31:0] b_mem_di, b_mem_dout;

    logic [31:0] ram_a [0:65535];
    logic        pre_we;
    logic [15:0] pre_addr;
    logic [31:0] pre_data;

    int          vectors;
    int          errors;
    int          lat_v, oth_v, own_v, wen_v;
    logic [31:0] maddr1_v, di1_v;

    dmem_arbiter #(.ADDR_WIDTH(16), .WAIT_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst),
        .p0_req(a_p0_req), .p0_we(a_p0_we), .p0_addr(a_p0_addr), .p0_wdata(a_p0_wdata),
        .p0_rdata(a_p0_rdata), .p0_stall(a_p0_stall), .p0_done(a_p0_done),
        .p1_req(a_p1_req), .p1_we(a_p1_we), .p1_addr(a_p1_addr), .p1_wdata(a_p1_wdata),
        .p1_rdata(a_p1_rdata), .p1_stall(a_p1_stall), .p1_done(a_p1_done),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_di(a_mem_di), .mem_dout(a_mem_dout),
        .busy(a_busy)
    );

    dmem_arbiter #(.ADDR_WIDTH(16), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst),
        .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
        .p0_rdata(b_p0_rdata), .p0_stall(b_p0_stall), .p0_done(b_p0_done),
        .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
        .p1_rdata(b_p1_rdata), .p1_stall(b_p1_stall), .p1_done(b_p1_done),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_di(b_mem_di), .mem_dout(b_mem_dout),
        .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM behind instance A, with a bench-side preload port.
    always @(posedge clk) begin
        if (pre_we) begin
            ram_a[pre_addr] <= pre_data;
        end else if (a_mem_we) begin
            ram_a[a_mem_addr] <= a_mem_di;
        end
        a_mem_dout <= ram_a[a_mem_addr];
    end

    // Instance B's RAM returns a pattern derived from the word address.
    always @(posedge clk) begin
        b_mem_dout <= {16'hC0DE, b_mem_addr};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] addr, input logic [31:0] data);
        pre_we   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Wait (bounded) for a done pulse on instance A, tallying stalls and write strobes.
    task automatic wait_done(input bit port);
        bit got;
        got = 1'b0; lat_v = 0; oth_v = 0; own_v = 0; wen_v = 0;
        maddr1_v = 32'd0; di1_v = 32'd0;
        while (!got && lat_v < 40) begin
            @(negedge clk);
            lat_v++;
            if (lat_v == 1) begin
                maddr1_v = 32'(a_mem_addr);
                di1_v    = a_mem_di;
            end
            if (a_mem_we) wen_v++;
            if (port ? a_p0_stall : a_p1_stall) oth_v++;
            if (port ? a_p1_done : a_p0_done) got = 1'b1;
            else if (port ? a_p1_stall : a_p0_stall) own_v++;
        end
        if (!got) lat_v = -1;
    endtask

    initial begin
        int n;
        bit got;
        vectors = 0; errors = 0;
        rst = 1'b1; pre_we = 1'b0; pre_addr = 16'd0; pre_data = 32'd0;
        a_p0_req = 1'b0; a_p0_we = 1'b0; a_p0_addr = 32'd0; a_p0_wdata = 32'd0;
        a_p1_req = 1'b0; a_p1_we = 1'b0; a_p1_addr = 32'd0; a_p1_wdata = 32'd0;
        b_p0_req = 1'b0; b_p0_we = 1'b0; b_p0_addr = 32'd0; b_p0_wdata = 32'd0;
        b_p1_req = 1'b0; b_p1_we = 1'b0; b_p1_addr = 32'd0; b_p1_wdata = 32'd0;
        @(negedge clk);
        preload(16'h0000, 32'd1);
        preload(16'h0001, 32'd2);
        preload(16'h0002, 32'd3);
        preload(16'h0080, 32'h1111_2222);
        preload(16'h0041, 32'h0BAD_F00D);

        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_mem_we", 32'(a_mem_we), 32'd0);
        chk("rst_mem_addr", 32'(a_mem_addr), 32'd0);
        chk("rst_mem_di", a_mem_di, 32'd0);
        chk("rst_p0_rdata", a_p0_rdata, 32'd0);
        chk("rst_p1_rdata", a_p1_rdata, 32'd0);
        chk("rst_done", {30'd0, a_p1_done, a_p0_done}, 32'd0);
        chk("rst_b_busy", 32'(b_busy), 32'd0);
        rst = 1'b0;

        // p0 write then read of byte address 0x100
        @(negedge clk);
        a_p0_req = 1'b1; a_p0_we = 1'b1; a_p0_addr = 32'h0000_0100; a_p0_wdata = 32'hDEAD_BEEF;
        #1 chk("wr_stall_at_req", 32'(a_p0_stall), 32'd1);
        wait_done(1'b0);
        chk("wr_latency", 32'(lat_v), 32'd7);
        chk("wr_stall_cycles", 32'(own_v), 32'd6);
        chk("wr_stall_at_done", 32'(a_p0_stall), 32'd0);
        chk("wr_mem_we_cycles", 32'(wen_v), 32'd1);
        chk("wr_mem_addr", maddr1_v, 32'h0000_0040);
        chk("wr_mem_di", di1_v, 32'hDEAD_BEEF);
        chk("wr_rdata_untouched", a_p0_rdata, 32'd0);
        a_p0_req = 1'b0;
        @(negedge clk);
        a_p0_req = 1'b1; a_p0_we = 1'b0;
        wait_done(1'b0);
        chk("rd_latency", 32'(lat_v), 32'd7);
        chk("rd_stall_cycles", 32'(own_v), 32'd6);
        chk("rd_mem_we_cycles", 32'(wen_v), 32'd0);
        chk("rd_mem_addr", maddr1_v, 32'h0000_0040);
        chk("rd_p0_rdata", a_p0_rdata, 32'hDEAD_BEEF);
        a_p0_req = 1'b0;

        // fresh reset, then simultaneous requests
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        a_p0_req = 1'b1; a_p0_addr = 32'h0000_0100;
        a_p1_req = 1'b1; a_p1_we = 1'b0; a_p1_addr = 32'h0000_0200;
        wait_done(1'b0);
        chk("tie1_p0_latency", 32'(lat_v), 32'd7);
        chk("tie1_p1_stalled", 32'(oth_v), 32'd7);
        chk("tie1_p0_rdata", a_p0_rdata, 32'hDEAD_BEEF);
        chk("tie1_p1_rdata_untouched", a_p1_rdata, 32'd0);
        a_p0_addr = 32'h0000_0104;
        wait_done(1'b1);
        chk("tie2_p1_latency", 32'(lat_v), 32'd8);
        chk("tie2_p0_stalled", 32'(oth_v), 32'd8);
        chk("tie2_p1_rdata", a_p1_rdata, 32'h1111_2222);
        a_p1_req = 1'b0;
        wait_done(1'b0);
        chk("tie2_p0_latency", 32'(lat_v), 32'd8);
        chk("tie2_p0_rdata", a_p0_rdata, 32'h0BAD_F00D);
        a_p0_req = 1'b0;

        // p1 back-to-back reads with req held high
        @(negedge clk);
        a_p1_req = 1'b1; a_p1_addr = 32'h0000_0000;
        wait_done(1'b1);
        chk("b2b0_latency", 32'(lat_v), 32'd7);
        chk("b2b0_rdata", a_p1_rdata, 32'd1);
        a_p1_addr = 32'h0000_0004;
        wait_done(1'b1);
        chk("b2b1_spacing", 32'(lat_v), 32'd8);
        chk("b2b1_rdata", a_p1_rdata, 32'd2);
        a_p1_addr = 32'h0000_0008;
        wait_done(1'b1);
        chk("b2b2_spacing", 32'(lat_v), 32'd8);
        chk("b2b2_rdata", a_p1_rdata, 32'd3);
        chk("b2b_p0_rdata_kept", a_p0_rdata, 32'h0BAD_F00D);
        a_p1_req = 1'b0;

        // reset asserted in WAIT of a p0 read
        @(negedge clk);
        a_p0_req = 1'b1; a_p0_addr = 32'h0000_0100;
        repeat (4) @(negedge clk);
        chk("rstmid_busy_before", 32'(a_busy), 32'd1);
        chk("rstmid_captured", a_p0_rdata, 32'hDEAD_BEEF);
        rst = 1'b1;
        #1;
        chk("rstmid_busy", 32'(a_busy), 32'd0);
        chk("rstmid_mem_we", 32'(a_mem_we), 32'd0);
        chk("rstmid_p0_done", 32'(a_p0_done), 32'd0);
        chk("rstmid_p0_rdata", a_p0_rdata, 32'd0);
        @(negedge clk); rst = 1'b0;
        wait_done(1'b0);
        chk("rstmid_resume_latency", 32'(lat_v), 32'd7);
        chk("rstmid_resume_rdata", a_p0_rdata, 32'hDEAD_BEEF);
        a_p0_req = 1'b0;

        // address changed during WAIT is ignored
        @(negedge clk);
        a_p0_req = 1'b1; a_p0_addr = 32'h0000_0104;
        repeat (3) @(negedge clk);
        a_p0_addr = 32'h0000_0100;
        wait_done(1'b0);
        chk("addrchg_latency", 32'(lat_v), 32'd4);
        chk("addrchg_mem_addr", 32'(a_mem_addr), 32'h0000_0041);
        chk("addrchg_rdata", a_p0_rdata, 32'h0BAD_F00D);
        a_p0_req = 1'b0;

        // WAIT_CYCLES=0 instance: address wrap and minimum latency
        @(negedge clk);
        b_p0_req = 1'b1; b_p0_addr = 32'hFFFF_FFFC;
        got = 1'b0; n = 0; maddr1_v = 32'd0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) maddr1_v = 32'(b_mem_addr);
            if (b_p0_done) got = 1'b1;
        end
        if (!got) n = -1;
        chk("w0_latency", 32'(n), 32'd3);
        chk("w0_mem_addr", maddr1_v, 32'h0000_FFFF);
        chk("w0_rdata", b_p0_rdata, 32'hC0DE_FFFF);
        b_p0_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("end_idle", {30'd0, b_busy, a_busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
